// File: rtl/vip_uart_rx_decoder.sv
// vip_uart_rx_decoder
//   8N1, LSB-first UART receiver feeding a small byte FIFO with a
//   valid/ready drain. It reports bad stop bits and FIFO overflow.
//
// Ports
//   clk_i        clock (single domain)
//   rst_i        synchronous, active-high reset
//   rx_i         serial line, asynchronous to clk_i, idle high
//   data_o       byte at the FIFO head
//   valid_o      FIFO not empty
//   ready_i      consumer accepts data_o (pop on valid_o && ready_i)
//   frame_err_o  one-cycle pulse when a byte is dropped for a bad stop bit
//   overflow_o   sticky; set when a byte is dropped because the FIFO is full
//   clr_i        clears overflow_o (a simultaneous set wins)
//   fill_o       current FIFO occupancy
module vip_uart_rx_decoder #(
  parameter int unsigned ClkPerBit = 16,
  parameter int unsigned FifoDepth = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rx_i,
  output logic [7:0]                     data_o,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic                           frame_err_o,
  output logic                           overflow_o,
  input  logic                           clr_i,
  output logic [$clog2(FifoDepth+1)-1:0] fill_o
);

  localparam int unsigned CntW  = $clog2(ClkPerBit);
  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned FillW = $clog2(FifoDepth + 1);

  localparam logic [CntW-1:0]  CntHalf = CntW'(ClkPerBit / 2 - 1);
  localparam logic [CntW-1:0]  CntLast = CntW'(ClkPerBit - 1);
  localparam logic [FillW-1:0] FillMax = FillW'(FifoDepth);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // Input synchroniser plus previous-value flop for start-edge detection
  logic sync1_q;
  logic rxs_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rxs_q   <= sync1_q;
      prev_q  <= rxs_q;
    end
  end

  // Frame decoder
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sr_q, sr_d;
  logic            frame_err_q, frame_err_d;
  logic            push;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sr_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sr_d        = sr_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Only a high-to-low transition starts a frame; a line stuck low does not.
        if (prev_q && !rxs_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!rxs_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DATA: begin
        // Sampling a full bit period after the start-bit centre lands on bit centres.
        if (cnt_q == CntLast) begin
          sr_d[idx_q] = rxs_q;
          cnt_d       = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      STOP: begin
        // Leaving mid stop bit lets a zero-idle-bit next frame be caught.
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs_q) begin
            push = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Byte FIFO
  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [FillW-1:0] count_q;
  logic            overflow_q;
  logic            full;
  logic            valid;
  logic            pop;
  logic            accept;
  logic            ovf_set;

  assign full    = (count_q == FillMax);
  assign valid   = (count_q != '0);
  assign pop     = valid && ready_i;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
  assign accept  = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= sr_q;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + FillW'(1);
        2'b01:   count_q <= count_q - FillW'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign data_o      = mem_q[rd_ptr_q];
  assign valid_o     = valid;
  assign fill_o      = count_q;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_vip_uart_rx_decoder.sv
// Directed testbench for vip_uart_rx_decoder (ClkPerBit=16, FifoDepth=8).
// Inputs change on the falling clock edge; outputs are observed away from
// the rising edge.
module tb_vip_uart_rx_decoder;

  localparam int unsigned ClkPerBit = 16;
  localparam int unsigned FifoDepth = 8;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overflow_o;
  logic       clr_i;
  logic [3:0] fill_o;

  int errors = 0;
  int checks = 0;

  // Observations gathered by the monitor
  logic [7:0] pops[$];
  int         ferr_cnt;
  int         valid_cycles;
  int         max_fill;

  vip_uart_rx_decoder #(
    .ClkPerBit(ClkPerBit),
    .FifoDepth(FifoDepth)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .clr_i      (clr_i),
    .fill_o     (fill_o)
  );

  always #5 clk_i = ~clk_i;

  // Samples 2 time units after each falling edge, well clear of both edges
  always @(negedge clk_i) begin
    #2;
    if (!rst_i) begin
      if (valid_o && ready_i) pops.push_back(data_o);
      if (valid_o) valid_cycles++;
      if (frame_err_o) ferr_cnt++;
      if (int'(fill_o) > max_fill) max_fill = int'(fill_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_mon();
    pops.delete();
    ferr_cnt     = 0;
    valid_cycles = 0;
    max_fill     = 0;
  endtask

  // Called at a falling edge; returns exactly 10 bit periods later, leaving
  // rx_i at the stop level so a following call makes a zero-idle-bit frame.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (ClkPerBit) @(negedge clk_i);
      rx_i = b[i];
    end
    repeat (ClkPerBit) @(negedge clk_i);
    rx_i = stop;
    repeat (ClkPerBit) @(negedge clk_i);
  endtask

  initial begin
    rst_i   = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b0;
    clr_i   = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk_i);

    // Reset state
    chk("rst_data", data_o, 32'h0);
    chk("rst_valid", valid_o, 32'h0);
    chk("rst_ferr", frame_err_o, 32'h0);
    chk("rst_ovf", overflow_o, 32'h0);
    chk("rst_fill", fill_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Single byte 0x41, consumer always ready
    ready_i = 1'b1;
    clear_mon();
    send_byte(8'h41, 1'b1);
    repeat (10) @(negedge clk_i);
    chk("b41_count", pops.size(), 32'd1);
    chk("b41_data", pops[0], 32'h41);
    chk("b41_valid_cycles", valid_cycles, 32'd1);
    chk("b41_max_fill", max_fill, 32'd1);
    chk("b41_ferr", ferr_cnt, 32'd0);

    // Short low glitch is rejected, then 0xA5 decodes
    clear_mon();
    rx_i = 1'b0;
    repeat (5) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (30) @(negedge clk_i);
    chk("glitch_pops", pops.size(), 32'd0);
    chk("glitch_fill", fill_o, 32'd0);
    send_byte(8'hA5, 1'b1);
    repeat (10) @(negedge clk_i);
    chk("a5_count", pops.size(), 32'd1);
    chk("a5_data", pops[0], 32'hA5);

    // Bad stop bit, line then held low
    clear_mon();
    send_byte(8'h55, 1'b0);
    chk("ferr_pulse", ferr_cnt, 32'd1);
    repeat (40) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("ferr_once", ferr_cnt, 32'd1);
    chk("ferr_pops", pops.size(), 32'd0);
    chk("ferr_fill", fill_o, 32'd0);
    chk("ferr_max_fill", max_fill, 32'd0);

    // Fill with 0x00..0x07, 9th byte overflows
    clear_mon();
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i), 1'b1);
      repeat (4) @(negedge clk_i);
    end
    chk("full_fill", fill_o, 32'd8);
    chk("full_no_ovf", overflow_o, 32'd0);
    send_byte(8'h08, 1'b1);
    repeat (4) @(negedge clk_i);
    chk("ovf_fill", fill_o, 32'd8);
    chk("ovf_set", overflow_o, 32'd1);
    chk("ovf_head_stable", data_o, 32'h00);
    ready_i = 1'b1;
    repeat (12) @(negedge clk_i);
    chk("drain_count", pops.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", pops[i], 32'(i));
    end
    chk("drain_valid", valid_o, 32'd0);
    chk("drain_fill", fill_o, 32'd0);
    chk("ovf_sticky", overflow_o, 32'd1);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    @(negedge clk_i);
    chk("ovf_clr", overflow_o, 32'd0);

    // Full FIFO: push cycle coincides with a single-cycle pop
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1);
      repeat (4) @(negedge clk_i);
    end
    chk("full2_fill", fill_o, 32'd8);
    clear_mon();
    fork
      send_byte(8'h99, 1'b1);
      begin
        // Push is decided in the cycle after the 154th falling edge of the frame
        repeat (154) @(negedge clk_i);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
      end
    join
    repeat (4) @(negedge clk_i);
    chk("pushpop_pops", pops.size(), 32'd1);
    chk("pushpop_head", pops[0], 32'h10);
    chk("pushpop_fill", fill_o, 32'd8);
    chk("pushpop_ovf", overflow_o, 32'd0);
    clear_mon();
    ready_i = 1'b1;
    repeat (12) @(negedge clk_i);
    chk("pushpop_drain", pops.size(), 32'd8);
    chk("pushpop_first", pops[0], 32'h11);
    chk("pushpop_last", pops[7], 32'h99);

    // Reset during DATA of 0x3C with a byte queued
    ready_i = 1'b0;
    send_byte(8'h5A, 1'b1);
    repeat (4) @(negedge clk_i);
    chk("pre_rst_data", data_o, 32'h5A);
    chk("pre_rst_valid", valid_o, 32'd1);
    clear_mon();
    fork
      send_byte(8'h3C, 1'b1);
      begin
        repeat (60) @(negedge clk_i);
        rst_i = 1'b1;
      end
    join
    @(negedge clk_i);
    chk("midrst_data", data_o, 32'h0);
    chk("midrst_valid", valid_o, 32'd0);
    chk("midrst_ferr", frame_err_o, 32'd0);
    chk("midrst_ovf", overflow_o, 32'd0);
    chk("midrst_fill", fill_o, 32'd0);
    rst_i   = 1'b0;
    ready_i = 1'b1;
    repeat (20) @(negedge clk_i);
    chk("midrst_no_byte", pops.size(), 32'd0);

    // Back-to-back frames with zero idle bits
    clear_mon();
    send_byte(8'hC3, 1'b1);
    send_byte(8'h7E, 1'b1);
    repeat (10) @(negedge clk_i);
    chk("b2b_count", pops.size(), 32'd2);
    chk("b2b_first", pops[0], 32'hC3);
    chk("b2b_second", pops[1], 32'h7E);
    chk("b2b_ferr", ferr_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
